// File: rtl/writer.sv
// Transmit side of the pin byte interface. Bytes arrive as single-cycle pulses,
// are queued in a small FIFO and presented to the host over a 4-phase req/ack.
module writer #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [7:0]    byte_in,
  input  logic          is_hash_in,
  input  logic          byte_pulse_in,
  output logic [7:0]    output_byte,
  output logic          output_is_hash,
  output logic          output_request,
  input  logic          output_ack,
  output logic          busy_out,
  output logic          overflow_out,
  output logic [CW-1:0] fifo_count_out
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [8:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ack_meta_q, ack_s_q;
  logic [7:0]      byte_q, byte_d;
  logic            tag_q, tag_d;
  logic            req_q, req_d;
  logic            ovf_q, ovf_d;
  logic            pop, push;
  logic            fifo_full, fifo_empty;

  assign fifo_full  = (count_q == CW'(DEPTH));
  assign fifo_empty = (count_q == '0);

  // Handshake FSM; launching a byte is the only event that pops the FIFO.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_q;
    tag_d   = tag_q;
    req_d   = req_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !ack_s_q) begin
          pop             = 1'b1;
          {tag_d, byte_d} = mem_q[rd_ptr_q];
          req_d           = 1'b1;
          state_d         = REQ;
        end
      end
      REQ: begin
        if (ack_s_q) begin
          req_d   = 1'b0;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!ack_s_q) begin
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // A full FIFO still accepts a pulse when the head leaves in the same cycle.
  always_comb begin
    push     = byte_pulse_in && (!fifo_full || pop);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    ovf_d = ovf_q || (byte_pulse_in && fifo_full && !pop);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
      byte_q     <= '0;
      tag_q      <= 1'b0;
      req_q      <= 1'b0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ack_meta_q <= output_ack;
      ack_s_q    <= ack_meta_q;
      byte_q     <= byte_d;
      tag_q      <= tag_d;
      req_q      <= req_d;
      ovf_q      <= ovf_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {is_hash_in, byte_in};
      end
    end
  end

  assign output_byte    = byte_q;
  assign output_is_hash = tag_q;
  assign output_request = req_q;
  assign overflow_out   = ovf_q;
  assign fifo_count_out = count_q;
  assign busy_out       = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_writer.sv
// Bench for writer: a queue-based host/FIFO model checked every cycle, plus
// directed handshake scenarios with literal expectations.
module tb_writer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          nrst;
  logic [7:0]    byte_in;
  logic          is_hash_in;
  logic          byte_pulse_in;
  logic [7:0]    output_byte;
  logic          output_is_hash;
  logic          output_request;
  logic          output_ack;
  logic          busy_out;
  logic          overflow_out;
  logic [CW-1:0] fifo_count_out;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  writer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .byte_in        (byte_in),
    .is_hash_in     (is_hash_in),
    .byte_pulse_in  (byte_pulse_in),
    .output_byte    (output_byte),
    .output_is_hash (output_is_hash),
    .output_request (output_request),
    .output_ack     (output_ack),
    .busy_out       (busy_out),
    .overflow_out   (overflow_out),
    .fifo_count_out (fifo_count_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference model: queue of pending bytes, ack seen through a 2-deep delay,
  // host phase 0 = waiting to launch, 1 = request up, 2 = waiting for ack to drop.
  logic [8:0] m_q [$];
  logic [8:0] m_head;
  int m_phase, m_byte, m_tag, m_req, m_ovf, m_ack_d1, m_ack_d2;

  always @(posedge clk) begin
    if (!nrst) begin
      m_q.delete();
      m_phase = 0; m_byte = 0; m_tag = 0; m_req = 0; m_ovf = 0;
      m_ack_d1 = 0; m_ack_d2 = 0;
    end else begin
      if (m_phase == 0 && m_q.size() > 0 && m_ack_d2 == 0) begin
        m_head  = m_q.pop_front();
        m_byte  = int'(m_head[7:0]);
        m_tag   = int'(m_head[8]);
        m_req   = 1;
        m_phase = 1;
      end else if (m_phase == 1 && m_ack_d2 == 1) begin
        m_req   = 0;
        m_phase = 2;
      end else if (m_phase == 2 && m_ack_d2 == 0) begin
        m_phase = 0;
      end
      if (byte_pulse_in) begin
        if (m_q.size() < DEPTH) m_q.push_back({is_hash_in, byte_in});
        else m_ovf = 1;
      end
      m_ack_d2 = m_ack_d1;
      m_ack_d1 = int'(output_ack);
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_byte", int'(output_byte), m_byte);
      chk("model_tag", int'(output_is_hash), m_tag);
      chk("model_req", int'(output_request), m_req);
      chk("model_ovf", int'(overflow_out), m_ovf);
      chk("model_count", int'(fifo_count_out), m_q.size());
      chk("model_busy", int'(busy_out), int'(m_phase != 0 || m_q.size() != 0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [7:0] b, input logic t);
    byte_in       = b;
    is_hash_in    = t;
    byte_pulse_in = 1'b1;
    tick();
    byte_pulse_in = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    tick();
    nrst = 1'b1;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (output_request !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk(name, int'(output_request), 1);
  endtask

  // One full host transaction, checking the pins stay frozen until RELEASE exits.
  task automatic handshake(input string name, input int exp_byte, input int exp_tag);
    logic [7:0] b;
    logic       t;
    int         n = 0;
    wait_req({name, "_req"});
    b = output_byte;
    t = output_is_hash;
    chk({name, "_byte"}, int'(b), exp_byte);
    chk({name, "_tag"}, int'(t), exp_tag);
    output_ack = 1'b1;
    while (output_request === 1'b1 && n < 10) begin
      tick();
      n++;
      chk({name, "_hold_byte"}, int'(output_byte), int'(b));
    end
    chk({name, "_req_fall"}, int'(output_request), 0);
    output_ack = 1'b0;
    repeat (3) begin
      tick();
      chk({name, "_rel_byte"}, int'(output_byte), int'(b));
      chk({name, "_rel_tag"}, int'(output_is_hash), int'(t));
    end
  endtask

  initial begin
    int n;
    nrst          = 1'b0;
    output_ack    = 1'b0;
    byte_in       = '0;
    is_hash_in    = 1'b0;
    byte_pulse_in = 1'b0;
    tick();
    tick();
    nrst   = 1'b1;
    cmp_en = 1'b1;
    chk("rst_req", int'(output_request), 0);
    chk("rst_count", int'(fifo_count_out), 0);
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_ovf", int'(overflow_out), 0);
    chk("rst_byte", int'(output_byte), 0);

    // Single byte: request two cycles after the pulse, falls three after ack.
    pulse(8'hA5, 1'b0);
    tick();
    chk("single_req", int'(output_request), 1);
    chk("single_byte", int'(output_byte), 'hA5);
    output_ack = 1'b1;
    n = 0;
    while (output_request === 1'b1 && n < 10) begin
      tick();
      n++;
    end
    chk("single_ack_latency", n, 3);
    output_ack = 1'b0;
    repeat (3) tick();
    chk("single_busy", int'(busy_out), 0);
    chk("single_count", int'(fifo_count_out), 0);

    // Burst of four, host idle.
    for (int i = 1; i <= 4; i++) pulse(8'(i), 1'b0);
    chk("burst_count", int'(fifo_count_out), 3);
    chk("burst_head", int'(output_byte), 'h01);
    for (int i = 1; i <= 4; i++) handshake("burst", i, 0);
    chk("burst_ovf", int'(overflow_out), 0);

    // Overflow: six pulses into a stalled host, last one dropped.
    for (int i = 0; i < 6; i++) pulse(8'(8'h10 + i), 1'b0);
    chk("ovf_count", int'(fifo_count_out), 4);
    chk("ovf_head", int'(output_byte), 'h10);
    chk("ovf_flag", int'(overflow_out), 1);
    for (int i = 0; i < 5; i++) handshake("ovf_drain", 'h10 + i, 0);
    chk("ovf_sticky", int'(overflow_out), 1);
    chk("ovf_empty", int'(fifo_count_out), 0);

    // Full FIFO held off by ack; pulse lands on the same edge as the launch pop.
    do_reset();
    output_ack = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) pulse(8'(8'h20 + i), 1'b0);
    chk("sim_full", int'(fifo_count_out), 4);
    chk("sim_noreq", int'(output_request), 0);
    output_ack = 1'b0;
    tick();
    tick();
    pulse(8'h24, 1'b0);
    chk("sim_count", int'(fifo_count_out), 4);
    chk("sim_req", int'(output_request), 1);
    chk("sim_ovf", int'(overflow_out), 0);
    for (int i = 0; i < 5; i++) handshake("sim_drain", 'h20 + i, 0);

    // Reset in REQ with ack high and two bytes queued.
    pulse(8'h30, 1'b0);
    pulse(8'h31, 1'b0);
    pulse(8'h32, 1'b0);
    chk("mid_count", int'(fifo_count_out), 2);
    output_ack = 1'b1;
    tick();
    tick();
    do_reset();
    chk("mid_req", int'(output_request), 0);
    chk("mid_count0", int'(fifo_count_out), 0);
    chk("mid_byte", int'(output_byte), 0);
    chk("mid_busy", int'(busy_out), 0);
    repeat (4) tick();
    pulse(8'h7E, 1'b0);
    repeat (4) begin
      tick();
      chk("mid_hold_off", int'(output_request), 0);
    end
    output_ack = 1'b0;
    handshake("mid_7e", 'h7E, 0);

    // Hash-tagged byte.
    pulse(8'hC3, 1'b1);
    handshake("tag", 'hC3, 1);
    chk("end_busy", int'(busy_out), 0);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/writer.md
Name: writer

Overview:
- Transmit end of the chip's pin-level byte interface: the mirror of the input path that turns pin handshakes into pulses.
- Accepts single-cycle byte pulses from the data router / hash generator (ciphertext or hash digest bytes) into a small FIFO.
- Presents each byte on the output pins using a 4-phase request/acknowledge handshake with the external host.
- Reports busy and overflow status back to the interface FSM.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- CW, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  system clock
- nrst  input  1  synchronous active-low reset
- byte_in  input  8  byte to transmit; sampled only when byte_pulse_in=1
- is_hash_in  input  1  tag: 1 = hash digest byte, 0 = cipher output byte
- byte_pulse_in  input  1  single-cycle strobe qualifying byte_in/is_hash_in
- output_byte  output  8  byte driven to chip pins; registered
- output_is_hash  output  1  tag driven to chip pins; registered
- output_request  output  1  4-phase request to host; registered
- output_ack  input  1  4-phase acknowledge from host; asynchronous pin
- busy_out  output  1  1 when FIFO is non-empty or a handshake is in progress
- overflow_out  output  1  sticky; set when a pulse is dropped because the FIFO is full
- fifo_count_out  output  CW  current FIFO occupancy, 0..DEPTH

Behaviour:
- Clock and reset: all state updates on posedge clk. Reset is synchronous: when nrst=0 at a posedge, all registers clear.
- Reset values: output_byte=0, output_is_hash=0, output_request=0, busy_out=0, overflow_out=0, fifo_count_out=0. FIFO pointers=0; state=IDLE; both ack synchronizer flops=0.
- Ack synchronizer: output_ack passes through 2 flops to give ack_s. All FSM decisions use ack_s only.
- FIFO: 9-bit entries {is_hash, byte}.
  - Push when byte_pulse_in=1 and (count<DEPTH or a pop occurs in the same cycle).
  - Pulse while count==DEPTH with no pop: data is dropped and overflow_out<=1. It stays 1 until reset.
  - Pointers wrap modulo DEPTH.
  - Push and pop in the same cycle: count unchanged.
- FSM states:
  - IDLE: if count>0 and ack_s==0, then pop the head; output_byte/output_is_hash <= head; output_request<=1; go to REQ. Otherwise stay.
  - REQ: output_request=1; data held stable. When ack_s==1: output_request<=0; go to RELEASE.
  - RELEASE: output_request=0; data held stable. When ack_s==0: go to IDLE.
- Latency:
  - Pulse into an empty, idle block: output_request rises 2 cycles after the pulse cycle (push at edge 1, pop/launch at edge 2).
  - Host ack rise to output_request fall: 3 cycles (2 sync + 1 register).
  - Back-to-back bytes: next request can launch on the cycle after RELEASE sees ack_s==0.
- Data stability rule: output_byte and output_is_hash change only on an IDLE->REQ transition. They are never modified while output_request=1 or in RELEASE.
- busy_out is registered-equivalent: (state!=IDLE) or (count!=0), computed from current registers.
- Reset mid-handshake: request drops on the reset edge and queued bytes are lost. After reset, no new request is issued until ack_s==0, so a host still holding ack high does not cause a spurious handshake.
- Glitch/duplicate protection: ack_s toggling while in IDLE has no effect.

Test Plan:
- Single byte: reset, pulse byte_in=0xA5/is_hash_in=0 → output_request=1 two cycles later with output_byte=0xA5. Host acks → request falls 3 cycles after ack rise. Host drops ack → busy_out=0, fifo_count_out=0.
- Burst: pulse 0x01,0x02,0x03,0x04 on consecutive cycles with host not acking → count reaches 3 with 0x01 on pins. Complete 4 handshakes → pins show 0x01,0x02,0x03,0x04 in order; overflow_out=0.
- Overflow: host stalls; pulse 6 bytes 0x10..0x15 (DEPTH=4) → first byte on pins, FIFO holds 4 bytes, 0x15 dropped, overflow_out=1. Draining delivers 0x10..0x14; overflow_out stays 1.
- Simultaneous push/pop: FIFO full, idle host, pulse arriving on the same cycle as the IDLE->REQ pop → byte accepted, count stays 4, overflow_out=0.
- Reset mid-handshake: in REQ with host ack high, assert nrst=0 for 1 cycle with 2 bytes queued → all outputs 0, count=0. Keep ack high 5 cycles and then pulse 0x7E → no request until ack drops; then 0x7E is sent.
- Tag path: pulse 0xC3 with is_hash_in=1 → output_is_hash=1 and output_byte=0xC3, both stable from request rise to RELEASE exit.
